// File: rtl/mem_port.sv
// mem_port: turns one-cycle fetch/load/store strobes into a single valid/ready bus
// transaction, with byte-lane steering, sign/zero extension and misalignment traps.
module mem_port #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rden,
    input  logic              wren,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        funct3,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [31:0]       req_wdata,
    output logic [3:0]        req_be,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_data
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, FIN} state_t;

    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lane_q;
    logic [2:0]       f3_q;
    logic             strobe, f3_ok, misalign, bad, to_hit;
    logic [3:0]       be_c;
    logic [31:0]      wdata_rep, rd_ext;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;

    assign strobe    = rden | wren;
    assign to_hit    = (TIMEOUT > 0) && (cnt == CNT_W'(TO_LAST));
    assign req_valid = (state == REQ);
    assign done      = (state == FIN);

    // Request-side decode of the live strobe inputs
    always_comb begin
        f3_ok = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
            default: f3_ok = 1'b0;
        endcase
        misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        bad = !f3_ok || misalign;
        case (funct3[1:0])
            2'b00: begin
                be_c      = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c      = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be_c      = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Response lane select and extension, driven by the latched request
    always_comb begin
        lane_b = rsp_data[{lane_q, 3'b000} +: 8];
        lane_h = lane_q[1] ? rsp_data[31:16] : rsp_data[15:0];
        case (f3_q)
            3'b000:  rd_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  rd_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  rd_ext = {24'd0, lane_b};
            3'b101:  rd_ext = {16'd0, lane_h};
            default: rd_ext = rsp_data;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (strobe) state_nxt = bad ? FIN : REQ;
            end
            REQ: begin
                if (req_ready)   state_nxt = req_we ? FIN : WAIT_RSP;
                else if (to_hit) state_nxt = FIN;
            end
            WAIT_RSP: begin
                if (rsp_valid || to_hit) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Stall counter restarts on every state change so REQ and WAIT_RSP each get a full budget
    always_ff @(posedge clk) begin
        if (rst)                                  cnt <= '0;
        else if (state_nxt != state)              cnt <= '0;
        else if (state == REQ || state == WAIT_RSP) cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata     <= '0;
            err       <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            lane_q    <= '0;
            f3_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe) begin
                        // wren wins when both strobes arrive together
                        req_we    <= wren;
                        req_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        req_wdata <= wdata_rep;
                        req_be    <= wren ? be_c : 4'b1111;
                        lane_q    <= addr[1:0];
                        f3_q      <= funct3;
                        rdata     <= '0;
                        err       <= bad;
                    end
                end
                REQ: begin
                    if (!req_ready && to_hit) err <= 1'b1;
                end
                WAIT_RSP: begin
                    if (rsp_valid)   rdata <= rd_ext;
                    else if (to_hit) err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port.sv
// Bench for mem_port: directed spec vectors, randomized transactions against a
// plain-arithmetic reference model, stalls, reset mid-transfer and timeouts.
module tb_mem_port;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rden, wren;
    logic [31:0] addr, wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata, req_addr, req_wdata, rsp_data;
    logic        done, err, req_valid, req_ready, req_we, rsp_valid;
    logic [3:0]  req_be;

    logic [31:0] t_rdata, t_req_addr, t_req_wdata, t_rsp_data;
    logic        t_done, t_err, t_req_valid, t_req_ready, t_req_we, t_rsp_valid;
    logic [3:0]  t_req_be;

    mem_port #(.ADDR_W(32), .TIMEOUT(0)) dut (
        .clk(clk), .rst(rst), .rden(rden), .wren(wren), .addr(addr), .wdata(wdata),
        .funct3(funct3), .rdata(rdata), .done(done), .err(err), .req_valid(req_valid),
        .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(rsp_valid), .rsp_data(rsp_data));

    mem_port #(.ADDR_W(32), .TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .rden(rden), .wren(wren), .addr(addr), .wdata(wdata),
        .funct3(funct3), .rdata(t_rdata), .done(t_done), .err(t_err), .req_valid(t_req_valid),
        .req_ready(t_req_ready), .req_we(t_req_we), .req_addr(t_req_addr),
        .req_wdata(t_req_wdata), .req_be(t_req_be), .rsp_valid(t_rsp_valid),
        .rsp_data(t_rsp_data));

    int total = 0;
    int bad   = 0;

    // Observations of one transaction
    int          o_done_n, o_hs, o_vcnt;
    logic        o_err, o_unstable, o_extra, o_we;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_be;

    // Reference model outputs
    logic        e_err;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd, e_addr;
    int          e_lat;

    typedef struct packed {
        logic        we;
        logic [31:0] a;
        logic [31:0] w;
        logic [2:0]  f3;
        logic [31:0] rdat;
        logic        e;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        int          lat;
    } vec_t;
    vec_t vecs [11];

    function automatic void model(input logic we, input logic [31:0] a, input logic [31:0] w,
                                  input logic [2:0] f3, input logic [31:0] rdat,
                                  input int rdly, input int rsp_dly);
        int sz, bv, hv;
        sz     = int'(f3 % 4);
        e_err  = (f3 == 3) || (f3 == 6) || (f3 == 7) ||
                 (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
        e_addr = a - a % 4;
        bv     = int'((rdat >> (8 * (a % 4))) % 256);
        hv     = int'((rdat >> (16 * ((a / 2) % 2))) % 65536);
        e_be   = 4'hF;
        e_wd   = w;
        if (we && sz == 0) begin
            e_be = 4'(1 << (a % 4));
            e_wd = (w % 256) * 32'h01010101;
        end
        if (we && sz == 1) begin
            e_be = ((a / 2) % 2 != 0) ? 4'hC : 4'h3;
            e_wd = (w % 65536) * 32'h00010001;
        end
        case (f3)
            3'd0:    e_rd = 32'(bv > 127 ? bv - 256 : bv);
            3'd1:    e_rd = 32'(hv > 32767 ? hv - 65536 : hv);
            3'd4:    e_rd = 32'(bv);
            3'd5:    e_rd = 32'(hv);
            default: e_rd = rdat;
        endcase
        if (e_err) e_rd = '0;
        e_lat = e_err ? 1 : (we ? 2 + rdly : 3 + rdly + rsp_dly);
    endfunction

    // Issues one strobe and plays the bus: ready after rdly valid cycles,
    // one-cycle response rsp_dly cycles after the handshake. Records what it saw.
    task automatic run_txn(input logic we, input logic both, input logic [31:0] a,
                           input logic [31:0] w, input logic [2:0] f3,
                           input int rdly, input int rsp_dly, input logic [31:0] rdat);
        logic pv, pr, hs_seen;
        int   wait_c, since;
        o_done_n = -1; o_hs = 0; o_vcnt = 0; o_unstable = 1'b0; o_extra = 1'b0;
        o_err = 1'b0; o_rdata = '0; o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
        pv = 1'b0; pr = 1'b0; hs_seen = 1'b0; wait_c = 0; since = 0;
        wren = we; rden = !we || both; addr = a; wdata = w; funct3 = f3;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                wren = 1'b0; rden = 1'b0;
                addr = $urandom; wdata = $urandom; funct3 = 3'($urandom_range(0, 7));
            end
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
            if (pv && pr) begin
                o_hs++; hs_seen = 1'b1; since = 0;
            end
            if (hs_seen && !we) begin
                if (since == rsp_dly) begin
                    rsp_valid = 1'b1; rsp_data = rdat;
                end
                since++;
            end
            if (req_valid) begin
                if (o_vcnt == 0) begin
                    o_addr = req_addr; o_wdata = req_wdata; o_be = req_be; o_we = req_we;
                end else if ({req_addr, req_wdata, req_be, req_we} !== {o_addr, o_wdata, o_be, o_we})
                    o_unstable = 1'b1;
                o_vcnt++;
                req_ready = (wait_c >= rdly);
                wait_c++;
            end else begin
                req_ready = 1'($urandom_range(0, 1));
            end
            pv = req_valid; pr = req_ready;
            if (done) begin
                if (o_done_n < 0) begin
                    o_done_n = n; o_err = err; o_rdata = rdata;
                end else o_extra = 1'b1;
            end
            if (o_done_n >= 0 && n > o_done_n) break;
        end
        req_ready = 1'b0;
        rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rden = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({done, err, req_valid, req_we, req_be} !== 8'h0)
            $display("FAIL reset_ctrl: got %b want 0", {done, err, req_valid, req_we, req_be});
        total++;
        if ({rdata, req_addr, req_wdata} !== 96'h0)
            $display("FAIL reset_data: got %h want 0", {rdata, req_addr, req_wdata});
        total++;
        if ({t_done, t_err, t_req_valid, t_rdata} !== 35'h0)
            $display("FAIL reset_t: got %h want 0", {t_done, t_err, t_req_valid, t_rdata});
        if ({done, err, req_valid, req_we, req_be} !== 8'h0) bad++;
        if ({rdata, req_addr, req_wdata} !== 96'h0) bad++;
        if ({t_done, t_err, t_req_valid, t_rdata} !== 35'h0) bad++;
        rden = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vecs[0]  = '{1'b1, 32'h100, 32'hDEADBEEF, 3'd2, 32'h0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0, 2};
        vecs[1]  = '{1'b1, 32'h103, 32'h000000A5, 3'd0, 32'h0, 1'b0, 4'h8, 32'hA5A5A5A5, 32'h0, 2};
        vecs[2]  = '{1'b0, 32'h102, 32'h0, 3'd0, 32'h80FF1234, 1'b0, 4'hF, 32'h0, 32'hFFFFFFFF, 3};
        vecs[3]  = '{1'b0, 32'h102, 32'h0, 3'd4, 32'h80FF1234, 1'b0, 4'hF, 32'h0, 32'h000000FF, 3};
        vecs[4]  = '{1'b0, 32'h102, 32'h0, 3'd1, 32'h80FF1234, 1'b0, 4'hF, 32'h0, 32'hFFFF80FF, 3};
        vecs[5]  = '{1'b0, 32'h102, 32'h0, 3'd5, 32'h80FF1234, 1'b0, 4'hF, 32'h0, 32'h000080FF, 3};
        vecs[6]  = '{1'b0, 32'h101, 32'h0, 3'd0, 32'h80FF1234, 1'b0, 4'hF, 32'h0, 32'h00000012, 3};
        vecs[7]  = '{1'b0, 32'h102, 32'h0, 3'd2, 32'h80FF1234, 1'b1, 4'hF, 32'h0, 32'h0, 1};
        vecs[8]  = '{1'b1, 32'h101, 32'h1234, 3'd1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 1};
        vecs[9]  = '{1'b0, 32'h100, 32'h0, 3'd3, 32'h80FF1234, 1'b1, 4'hF, 32'h0, 32'h0, 1};
        vecs[10] = '{1'b1, 32'h102, 32'h0000BEEF, 3'd1, 32'h0, 1'b0, 4'hC, 32'hBEEFBEEF, 32'h0, 2};
        foreach (vecs[i]) begin
            run_txn(vecs[i].we, 1'b0, vecs[i].a, vecs[i].w, vecs[i].f3, 0, 0, vecs[i].rdat);
            total++;
            if (o_done_n !== vecs[i].lat) begin
                bad++; $display("FAIL dir%0d latency: got %0d want %0d", i, o_done_n, vecs[i].lat);
            end
            total++;
            if (o_err !== vecs[i].e) begin
                bad++; $display("FAIL dir%0d err: got %b want %b", i, o_err, vecs[i].e);
            end
            total++;
            if (o_hs !== (vecs[i].e ? 0 : 1)) begin
                bad++; $display("FAIL dir%0d handshakes: got %0d want %0d", i, o_hs, vecs[i].e ? 0 : 1);
            end
            total++;
            if (o_extra !== 1'b0) begin
                bad++; $display("FAIL dir%0d done_width: got extra done cycle want single pulse", i);
            end
            if (vecs[i].e) begin
                total++;
                if (o_rdata !== 32'h0 || o_vcnt !== 0) begin
                    bad++; $display("FAIL dir%0d err_quiet: got rdata=%h valid_cycles=%0d want 0/0", i, o_rdata, o_vcnt);
                end
            end else begin
                total++;
                if ({o_addr, o_be, o_we} !== {32'h100, vecs[i].be, vecs[i].we}) begin
                    bad++; $display("FAIL dir%0d req: got addr=%h be=%b we=%b want addr=100 be=%b we=%b", i, o_addr, o_be, o_we, vecs[i].be, vecs[i].we);
                end
                total++;
                if (vecs[i].we ? (o_wdata !== vecs[i].wd) : (o_rdata !== vecs[i].rd)) begin
                    bad++; $display("FAIL dir%0d data: got wdata=%h rdata=%h want %h", i, o_wdata, o_rdata, vecs[i].we ? vecs[i].wd : vecs[i].rd);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  vf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic        we;
        logic [31:0] a, w, rdat;
        logic [2:0]  f3;
        int          rdly, rsd;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            a = $urandom; w = $urandom; rdat = $urandom;
            f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : vf[$urandom_range(0, 4)];
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'($urandom_range(0, 1) * 2);
            rdly = $urandom_range(0, 3); rsd = $urandom_range(0, 3);
            model(we, a, w, f3, rdat, rdly, rsd);
            run_txn(we, 1'b0, a, w, f3, rdly, rsd, rdat);
            total++;
            if (o_done_n !== e_lat || o_err !== e_err || o_extra !== 1'b0) begin
                bad++; $display("FAIL rnd%0d done: got lat=%0d err=%b extra=%b want lat=%0d err=%b extra=0", i, o_done_n, o_err, o_extra, e_lat, e_err);
            end
            total++;
            if (o_hs !== (e_err ? 0 : 1) || o_unstable !== 1'b0) begin
                bad++; $display("FAIL rnd%0d bus: got hs=%0d unstable=%b want hs=%0d unstable=0", i, o_hs, o_unstable, e_err ? 0 : 1);
            end
            if (!e_err) begin
                total++;
                if ({o_addr, o_be, o_we} !== {e_addr, e_be, we} || (we && o_wdata !== e_wd)) begin
                    bad++; $display("FAIL rnd%0d req: got addr=%h be=%b we=%b wd=%h want addr=%h be=%b we=%b wd=%h", i, o_addr, o_be, o_we, o_wdata, e_addr, e_be, we, e_wd);
                end
            end
            if (!we || e_err) begin
                total++;
                if (o_rdata !== e_rd) begin
                    bad++; $display("FAIL rnd%0d rdata: got %h want %h (f3=%0d a=%h)", i, o_rdata, e_rd, f3, a);
                end
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_stall();
        logic held;
        run_txn(1'b0, 1'b0, 32'h204, 32'h0, 3'd2, 5, 1, 32'h13579BDF);
        total++;
        if (o_vcnt !== 6 || o_hs !== 1 || o_unstable !== 1'b0) begin
            bad++; $display("FAIL stall_bus: got valid_cycles=%0d hs=%0d unstable=%b want 6/1/0", o_vcnt, o_hs, o_unstable);
        end
        total++;
        if (o_done_n !== 9 || o_rdata !== 32'h13579BDF || o_addr !== 32'h204) begin
            bad++; $display("FAIL stall_result: got lat=%0d rdata=%h addr=%h want 9/13579bdf/204", o_done_n, o_rdata, o_addr);
        end
        held = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (rdata !== 32'h13579BDF || done !== 1'b0) held = 1'b0;
        end
        total++;
        if (held !== 1'b1) begin
            bad++; $display("FAIL rdata_hold: got rdata=%h done=%b want 13579bdf/0", rdata, done);
        end
    endtask

    task automatic test_both_strobes();
        run_txn(1'b1, 1'b1, 32'h308, 32'hCAFEF00D, 3'd2, 0, 0, 32'h0);
        total++;
        if (o_we !== 1'b1 || o_done_n !== 2 || o_wdata !== 32'hCAFEF00D) begin
            bad++; $display("FAIL both_strobes: got we=%b lat=%0d wd=%h want 1/2/cafef00d", o_we, o_done_n, o_wdata);
        end
    endtask

    task automatic test_rst_mid();
        int dn;
        req_ready = 1'b0;
        rden = 1'b1; addr = 32'h400; funct3 = 3'd2;
        @(posedge clk); #1;
        rden = 1'b0;
        total++;
        if (req_valid !== 1'b1) begin
            bad++; $display("FAIL rstmid_req: got req_valid=%b want 1", req_valid);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (req_valid !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rstmid_drop: got req_valid=%b done=%b want 0/0", req_valid, done);
        end
        dn = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || req_valid) dn++;
        end
        total++;
        if (dn !== 0) begin
            bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", dn);
        end
    endtask

    task automatic test_timeout();
        int          dn, vl4, vl5;
        logic        e;
        logic [31:0] r;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        // Response timeout: handshake immediately, no rsp ever
        t_req_ready = 1'b1;
        rden = 1'b1; addr = 32'h300; funct3 = 3'd2;
        dn = -1; e = 1'b0; r = 32'hX;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (n == 1) rden = 1'b0;
            if (t_done && dn < 0) begin
                dn = n; e = t_err; r = t_rdata;
            end
        end
        total++;
        if (dn !== 6 || e !== 1'b1 || r !== 32'h0) begin
            bad++; $display("FAIL timeout_rsp: got done@%0d err=%b rdata=%h want 6/1/0", dn, e, r);
        end
        // Request timeout: ready never rises
        t_req_ready = 1'b0;
        rden = 1'b1; addr = 32'h304; funct3 = 3'd2;
        dn = -1; e = 1'b0; vl4 = 0; vl5 = 1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) rden = 1'b0;
            if (n == 4) vl4 = int'(t_req_valid);
            if (n == 5) vl5 = int'(t_req_valid);
            if (t_done && dn < 0) begin
                dn = n; e = t_err;
            end
        end
        total++;
        if (dn !== 5 || e !== 1'b1 || vl4 !== 1 || vl5 !== 0) begin
            bad++; $display("FAIL timeout_req: got done@%0d err=%b valid@4=%0d valid@5=%0d want 5/1/1/0", dn, e, vl4, vl5);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rden = 1'b0; wren = 1'b0; addr = '0; wdata = '0; funct3 = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        t_req_ready = 1'b0; t_rsp_valid = 1'b0; t_rsp_data = 32'h5A5A5A5A;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_both_strobes();
        test_rst_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
